// File: rtl/sd_rx_fifo_sc.sv
// Single-clock SD receive FIFO: packs 1-bit/4-bit data-line samples MSB-first into
// WORD_W-bit words and buffers DEPTH of them. Optional sticky overflow: SD_RX_FIFO_ERR_EN.
module sd_rx_fifo_sc #(
  parameter int WORD_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int LW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wide,
  input  logic              flush,
  input  logic [3:0]        d,
  input  logic              wr,
  input  logic              rd,
  output logic [WORD_W-1:0] q,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              partial,
  output logic              ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WORD_W + 1);

  localparam logic [CW-1:0] SAMP_NARROW = CW'(WORD_W);
  localparam logic [CW-1:0] SAMP_WIDE   = CW'(WORD_W / 4);
  localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF      = LW'(AF_LEVEL);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wide_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  logic              clr;
  logic              discard;
  logic [WORD_W-1:0] base_sh;
  logic [CW-1:0]     base_cnt;
  logic [WORD_W-1:0] sh_in;
  logic [CW-1:0]     cnt_inc;
  logic              word_done;
  logic              pop;
  logic              push;

  assign clr = rst | flush;

  // Flags decode registered state only, so no wr/rd path reaches them.
  assign level       = level_q;
  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_FULL);
  assign almost_full = (level_q >= LVL_AF);
  assign partial     = (cnt_q != '0);
  assign q           = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // A bus-width change abandons any half-built word; a same-cycle sample starts afresh.
    discard  = partial && (wide != wide_q);
    base_sh  = discard ? '0 : sh_q;
    base_cnt = discard ? '0 : cnt_q;

    sh_in     = wide ? {base_sh[WORD_W-5:0], d} : {base_sh[WORD_W-2:0], d[0]};
    cnt_inc   = base_cnt + CW'(1);
    word_done = wr && (cnt_inc == (wide ? SAMP_WIDE : SAMP_NARROW));

    if (wr) begin
      sh_d  = sh_in;
      cnt_d = word_done ? '0 : cnt_inc;
    end else begin
      sh_d  = base_sh;
      cnt_d = base_cnt;
    end

    pop  = rd && !empty;
    push = word_done && (!full || pop);

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    wide_q <= wide;
    if (clr) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; q is masked to zero while empty, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= sh_in;
  end

`ifdef SD_RX_FIFO_ERR_EN
  logic ovf_q;
  logic drop;

  assign drop = word_done && full && !pop;
  assign ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (clr)       ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sd_rx_fifo_sc.sv
// Directed self-checking bench for sd_rx_fifo_sc (WORD_W=32, DEPTH=8, AF_LEVEL=6).
module tb_sd_rx_fifo_sc;

  localparam int WORD_W   = 32;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int LW       = 4;

`ifdef SD_RX_FIFO_ERR_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, wide, flush, wr, rd;
  logic [3:0]        d;
  logic [WORD_W-1:0] q;
  logic              full, almost_full, empty, partial, ovf;
  logic [LW-1:0]     level;

  int total = 0;
  int bad   = 0;

  sd_rx_fifo_sc #(.WORD_W(WORD_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .wide(wide), .flush(flush), .d(d), .wr(wr), .rd(rd),
    .q(q), .full(full), .almost_full(almost_full), .empty(empty),
    .level(level), .partial(partial), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] n);
    wide = 1'b1; d = n; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) nib(w[i*4 +: 4]);
  endtask

  task automatic bit1(input logic b);
    wide = 1'b0; d = {3'b000, b}; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, q, exp);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  logic [31:0] w;

  initial begin
    rst = 1'b1; wide = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; d = 4'h0;
    tick(); tick();
    rst = 1'b0;

    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_level", level, 0);
    check("rst_partial", partial, 0);
    check("rst_ovf", ovf, 0);
    check("rst_q", q, 0);

    // 1: nibble packing
    for (int i = 1; i <= 7; i++) nib(4'(i));
    check("nib_partial7", partial, 1);
    check("nib_empty7", empty, 1);
    nib(4'h8);
    check("nib_empty", empty, 0);
    check("nib_level", level, 1);
    check("nib_partial", partial, 0);
    pop_check("nib_q", 32'h12345678);
    check("nib_empty_after_pop", empty, 1);

    // 2: 1-bit packing
    w = 32'hA5A5_0F0F;
    for (int i = 31; i >= 0; i--) begin
      bit1(w[i]);
      if (i > 0) check($sformatf("bit_partial_%0d", 32 - i), partial, 1);
    end
    check("bit_level", level, 1);
    check("bit_partial_done", partial, 0);
    pop_check("bit_q", 32'hA5A5_0F0F);

    // 3: fill and overflow
    for (int k = 1; k <= 8; k++) push_word(32'hC0DE_0000 | k);
    check("fill_full", full, 1);
    check("fill_level", level, 8);
    check("fill_af", almost_full, 1);
    check("fill_ovf_pre", ovf, 0);
    push_word(32'hC0DE_0009);
    check("drop_level", level, 8);
    check("drop_partial", partial, 0);
    check("drop_ovf", ovf, OVF_EXP);
    for (int k = 1; k <= 8; k++) pop_check($sformatf("drain_%0d", k), 32'hC0DE_0000 | k);
    check("drain_empty", empty, 1);
    check("drain_ovf_sticky", ovf, OVF_EXP);
    do_flush();
    check("flush_ovf", ovf, 0);

    // 4: wrap and simultaneous push/pop at full
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) push_word(32'hB000_0000 | (r * 16 + k));
      check($sformatf("wrap_level_%0d", r), level, 5);
      for (int k = 0; k < 5; k++)
        pop_check($sformatf("wrap_%0d_%0d", r, k), 32'hB000_0000 | (r * 16 + k));
    end
    check("wrap_empty", empty, 1);
    for (int k = 1; k <= 8; k++) push_word(32'hD000_0000 | k);
    check("sim_full", full, 1);
    w = 32'hD000_00FF;
    for (int i = 7; i >= 1; i--) nib(w[i*4 +: 4]);
    wide = 1'b1; d = w[3:0]; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("sim_level", level, 8);
    check("sim_ovf", ovf, 0);
    for (int k = 2; k <= 8; k++) pop_check($sformatf("sim_pop_%0d", k), 32'hD000_0000 | k);
    pop_check("sim_pop_last", 32'hD000_00FF);
    check("sim_empty", empty, 1);

    // 5: mode change mid-word (first narrow sample in the switching cycle), then flush
    nib(4'h9); nib(4'hA); nib(4'hB);
    check("mode_partial", partial, 1);
    w = 32'h0F1E_2D3C;
    for (int i = 31; i >= 1; i--) bit1(w[i]);
    check("mode_level31", level, 0);
    bit1(w[0]);
    check("mode_level", level, 1);
    check("mode_partial_done", partial, 0);
    pop_check("mode_q", 32'h0F1E_2D3C);
    for (int k = 0; k < 4; k++) push_word(32'hE000_0000 | k);
    nib(4'h1); nib(4'h2);
    check("pre_flush_level", level, 4);
    do_flush();
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_partial", partial, 0);
    check("flush_ovf2", ovf, 0);
    check("flush_q", q, 0);

    // 6: almost-full threshold and read on empty
    for (int k = 1; k <= 5; k++) push_word(32'hF000_0000 | k);
    check("af_at5", almost_full, 0);
    push_word(32'hF000_0006);
    check("af_at6", almost_full, 1);
    check("af_full6", full, 0);
    do_flush();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("erd_level", level, 0);
    check("erd_q", q, 0);
    check("erd_empty", empty, 1);
    check("erd_ovf", ovf, 0);
    push_word(32'h1234_ABCD);
    pop_check("erd_after_q", 32'h1234_ABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
